// File: rtl/sram_nbit_ctrl_if.sv
// rtl/sram_nbit_ctrl_if.sv - request/response bundle for the swept-init SRAM controller
interface sram_nbit_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] wmask;
  logic              clear;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;
  logic              init_done;

  modport master (
    output req, we, addr, wdata, wmask, clear,
    input  ready, rdata, rvalid, err, init_done
  );

  modport slave (
    input  req, we, addr, wdata, wmask, clear,
    output ready, rdata, rvalid, err, init_done
  );
endinterface

// File: rtl/sram_nbit_ctrl.sv
// rtl/sram_nbit_ctrl.sv - single-port SRAM with bit-masked writes and an init sweep
// Memory is filled with INIT_VAL one word per cycle after reset or clear.
module sram_nbit_ctrl #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 4,
  parameter int              DEPTH    = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_nbit_ctrl_if.slave  bus
);

  typedef enum logic {INIT, IDLE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              init_done_q, init_done_d;

  logic ready;
  logic accept;
  logic in_range;

  assign ready    = (state_q == IDLE) && !bus.clear;
  assign accept   = bus.req && ready;
  assign in_range = {1'b0, bus.addr} < DEPTH_C;

  assign bus.ready     = ready;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;
  assign bus.init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST_C) begin
          state_d     = IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clear) begin
          state_d     = INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (accept) begin
          if (!in_range) begin
            err_d = 1'b1;
            if (!bus.we) begin
              rdata_d  = '0;
              rvalid_d = 1'b1;
            end
          end else if (!bus.we) begin
            rdata_d  = mem[bus.addr];
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage has no reset; the sweep is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (accept && bus.we && in_range) begin
      mem[bus.addr] <= (mem[bus.addr] & ~bus.wmask) | (bus.wdata & bus.wmask);
    end
  end

endmodule

// File: tb/tb_sram_nbit_ctrl.sv
// tb/tb_sram_nbit_ctrl.sv - directed self-checking bench for sram_nbit_ctrl
module tb_sram_nbit_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;
  logic saw_rvalid;
  logic [7:0] exp_mem [12];

  sram_nbit_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sram_nbit_ctrl #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] m);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.wmask = m;
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    saw_rvalid = 1'b0;
    while (!bus.ready && n < 40) begin
      tick();
      n++;
      if (bus.rvalid) saw_rvalid = 1'b1;
    end
    chk({tag, "_sweep_cycles"}, n, 12);
    chk({tag, "_init_done"}, bus.init_done, 1);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    bus.clear = 1'b0;
    for (int i = 0; i < 12; i++) exp_mem[i] = 8'hA5;

    tick();
    tick();
    chk("rst_ready", bus.ready, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rdata", bus.rdata, 0);

    rst_n = 1'b1;
    wait_ready("boot");

    // back-to-back reads of every word
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 4'(i), 0, 0);
      tick();
      chk($sformatf("init_rvalid_%0d", i), bus.rvalid, 1);
      chk($sformatf("init_rdata_%0d", i), bus.rdata, 8'hA5);
    end
    drive(0, 0, 0, 0, 0);
    tick();
    chk("idle_rvalid", bus.rvalid, 0);

    drive(1, 1, 3, 8'h3C, 8'hFF);
    tick();
    chk("wr3_rvalid", bus.rvalid, 0);
    chk("wr3_err", bus.err, 0);
    drive(1, 0, 3, 0, 0);
    tick();
    chk("rd3_rvalid", bus.rvalid, 1);
    chk("rd3_rdata", bus.rdata, 8'h3C);
    exp_mem[3] = 8'h3C;

    drive(1, 1, 5, 8'h00, 8'h0F);
    tick();
    drive(1, 0, 5, 0, 0);
    tick();
    chk("rd5_masked", bus.rdata, 8'hA0);
    exp_mem[5] = 8'hA0;

    drive(1, 0, 13, 0, 0);
    tick();
    chk("rd13_rvalid", bus.rvalid, 1);
    chk("rd13_err", bus.err, 1);
    chk("rd13_rdata", bus.rdata, 0);
    drive(1, 1, 14, 8'hFF, 8'hFF);
    tick();
    chk("wr14_err", bus.err, 1);
    chk("wr14_rvalid", bus.rvalid, 0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("err_one_cycle", bus.err, 0);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 4'(i), 0, 0);
      tick();
      chk($sformatf("after_oor_%0d", i), bus.rdata, exp_mem[i]);
    end

    drive(1, 1, 7, 8'h42, 8'hFF);
    tick();
    drive(1, 1, 2, 8'h11, 8'hFF);
    bus.clear = 1'b1;
    #1;
    chk("clear_ready", bus.ready, 0);
    tick();
    bus.clear = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("clear_init_done", bus.init_done, 0);
    chk("clear_no_rvalid", bus.rvalid, 0);
    wait_ready("clear");
    drive(1, 0, 2, 0, 0);
    tick();
    chk("clear_rd2", bus.rdata, 8'hA5);
    drive(1, 1, 7, 8'h42, 8'hFF);
    tick();
    drive(0, 0, 0, 0, 0);

    // reset partway through a sweep; the sweep must restart from word 0
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", bus.rdata, 0);
    chk("midrst_ready", bus.ready, 0);
    chk("midrst_init_done", bus.init_done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1, 1, 9, 8'h00, 8'hFF);
    wait_ready("rst");
    chk("rst_sweep_no_rvalid", saw_rvalid, 0);
    drive(1, 0, 9, 0, 0);
    tick();
    chk("rst_rd9", bus.rdata, 8'hA5);
    drive(1, 0, 7, 0, 0);
    tick();
    chk("rst_rd7", bus.rdata, 8'hA5);
    drive(0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
